// File: rtl/grom_boot_ctrl.sv
// Boot loader for the program RAM: holds the CPU in reset while a length-prefixed
// byte stream is written into RAM, then hands the RAM port back to the CPU.
module grom_boot_ctrl #(
  parameter int RELEASE_CYCLES = 4
) (
  input  logic        i_Clk,
  input  logic        reset,
  input  logic        i_Start,
  input  logic        i_Rx_Valid,
  input  logic [7:0]  i_Rx_Byte,
  output logic        o_Rx_Ready,
  input  logic [11:0] i_Cpu_Addr,
  input  logic [7:0]  i_Cpu_Data,
  input  logic        i_Cpu_We,
  input  logic        i_Cpu_Ioreq,
  output logic        o_Cpu_Reset,
  output logic [11:0] o_Mem_Addr,
  output logic [7:0]  o_Mem_Data,
  output logic        o_Mem_We,
  output logic        o_Busy,
  output logic        o_Done
);

  localparam logic [3:0] CNT_LAST = 4'(RELEASE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_LEN_HI  = 3'd0,
    S_LEN_LO  = 3'd1,
    S_DATA    = 3'd2,
    S_RELEASE = 3'd3,
    S_IDLE    = 3'd4
  } state_t;

  state_t      r_State, w_Next;
  logic [11:0] r_Len;
  logic [11:0] r_Addr;
  logic [3:0]  r_Cnt;
  logic        r_Done;

  logic        w_Xfer;
  logic [11:0] w_Len_M1;
  logic        w_Last;
  logic        w_Cnt_End;

  assign w_Xfer    = i_Rx_Valid & o_Rx_Ready;
  assign w_Len_M1  = r_Len - 12'd1;
  // len==0 wraps to 0xFFF, giving a full 4096-byte load
  assign w_Last    = (r_Addr == w_Len_M1);
  assign w_Cnt_End = (r_Cnt == CNT_LAST);

  always_ff @(posedge i_Clk or posedge reset) begin
    if (reset) r_State <= S_LEN_HI;
    else       r_State <= w_Next;
  end

  always_comb begin
    w_Next      = r_State;
    o_Rx_Ready  = 1'b0;
    o_Cpu_Reset = 1'b1;
    o_Busy      = 1'b1;
    o_Mem_Addr  = r_Addr;
    o_Mem_Data  = i_Rx_Byte;
    o_Mem_We    = 1'b0;
    case (r_State)
      S_LEN_HI: begin
        o_Rx_Ready = 1'b1;
        if (w_Xfer) w_Next = S_LEN_LO;
      end
      S_LEN_LO: begin
        o_Rx_Ready = 1'b1;
        if (w_Xfer) w_Next = S_DATA;
      end
      S_DATA: begin
        o_Rx_Ready = 1'b1;
        o_Mem_We   = w_Xfer;
        if (w_Xfer && w_Last) w_Next = S_RELEASE;
      end
      S_RELEASE: begin
        if (w_Cnt_End) w_Next = S_IDLE;
      end
      S_IDLE: begin
        o_Cpu_Reset = 1'b0;
        o_Busy      = 1'b0;
        o_Mem_Addr  = i_Cpu_Addr;
        o_Mem_Data  = i_Cpu_Data;
        o_Mem_We    = i_Cpu_We & ~i_Cpu_Ioreq;
        if (i_Start) w_Next = S_LEN_HI;
      end
      default: w_Next = S_LEN_HI;
    endcase
  end

  // Load datapath: length, load address and release timer
  always_ff @(posedge i_Clk or posedge reset) begin
    if (reset) begin
      r_Len  <= '0;
      r_Addr <= '0;
      r_Cnt  <= '0;
      r_Done <= 1'b0;
    end else begin
      r_Done <= (r_State == S_RELEASE) && w_Cnt_End;
      case (r_State)
        S_LEN_HI: if (w_Xfer) r_Len[11:8] <= i_Rx_Byte[3:0];
        S_LEN_LO: begin
          if (w_Xfer) begin
            r_Len[7:0] <= i_Rx_Byte;
            r_Addr     <= '0;
          end
        end
        S_DATA: begin
          if (w_Xfer) r_Addr <= r_Addr + 12'd1;
          r_Cnt <= '0;
        end
        S_RELEASE: r_Cnt <= r_Cnt + 4'd1;
        default: ;
      endcase
    end
  end

  assign o_Done = r_Done;

endmodule

// File: tb/tb_grom_boot_ctrl.sv
// Directed bench for grom_boot_ctrl: inputs driven at the falling edge, outputs checked 1ns later.
module tb_grom_boot_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        rx_ready;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_we;
  logic        cpu_ioreq;
  logic        cpu_reset;
  logic [11:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  grom_boot_ctrl #(.RELEASE_CYCLES(4)) dut (
    .i_Clk      (clk),
    .reset      (rst),
    .i_Start    (start),
    .i_Rx_Valid (rx_valid),
    .i_Rx_Byte  (rx_byte),
    .o_Rx_Ready (rx_ready),
    .i_Cpu_Addr (cpu_addr),
    .i_Cpu_Data (cpu_data),
    .i_Cpu_We   (cpu_we),
    .i_Cpu_Ioreq(cpu_ioreq),
    .o_Cpu_Reset(cpu_reset),
    .o_Mem_Addr (mem_addr),
    .o_Mem_Data (mem_data),
    .o_Mem_We   (mem_we),
    .o_Busy     (busy),
    .o_Done     (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle with a valid byte; optionally check the same-cycle RAM write
  task automatic xfer(input logic [7:0] b, input logic chk_wr, input logic [11:0] addr, input string tag);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = b;
    #1;
    if (chk_wr) begin
      chk({tag, "_we"},   32'(mem_we),   32'd1);
      chk({tag, "_addr"}, 32'(mem_addr), 32'(addr));
      chk({tag, "_data"}, 32'(mem_data), 32'(b));
    end
  endtask

  // Idle the stream and walk through the 4 release cycles and the done pulse
  task automatic release_chk(input string tag);
    @(negedge clk);
    rx_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk({tag, "_rel_cpurst"}, 32'(cpu_reset), 32'd1);
      chk({tag, "_rel_rdy"},    32'(rx_ready),  32'd0);
      chk({tag, "_rel_done"},   32'(done),      32'd0);
      @(negedge clk);
    end
    #1;
    chk({tag, "_done"},       32'(done),      32'd1);
    chk({tag, "_idle_cpurst"}, 32'(cpu_reset), 32'd0);
    chk({tag, "_idle_busy"},  32'(busy),      32'd0);
    @(negedge clk);
    #1;
    chk({tag, "_done_clr"},   32'(done),      32'd0);
  endtask

  task automatic do_start;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("start_cpurst", 32'(cpu_reset), 32'd1);
    chk("start_rdy",    32'(rx_ready),  32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
    cpu_addr = 12'h000; cpu_data = 8'h00; cpu_we = 1'b0; cpu_ioreq = 1'b0;
    #12;
    chk("rst_cpurst", 32'(cpu_reset), 32'd1);
    chk("rst_busy",   32'(busy),      32'd1);
    chk("rst_we",     32'(mem_we),    32'd0);
    chk("rst_done",   32'(done),      32'd0);
    chk("rst_rdy",    32'(rx_ready),  32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Basic 3-byte load, transfer on the first edge after reset
    rx_valid = 1'b1; rx_byte = 8'h00;
    xfer(8'h03, 1'b0, 12'h000, "b_len");
    xfer(8'hA1, 1'b1, 12'h000, "b_w0");
    xfer(8'hB2, 1'b1, 12'h001, "b_w1");
    xfer(8'hC3, 1'b1, 12'h002, "b_w2");
    release_chk("b");

    // CPU owns the RAM port in IDLE; the loader stream is ignored
    @(negedge clk);
    cpu_addr = 12'h123; cpu_data = 8'h55; cpu_we = 1'b1; cpu_ioreq = 1'b0;
    rx_valid = 1'b1; rx_byte = 8'h99;
    #1;
    chk("cpu_we",   32'(mem_we),   32'd1);
    chk("cpu_addr", 32'(mem_addr), 32'h123);
    chk("cpu_data", 32'(mem_data), 32'h55);
    chk("idle_rdy", 32'(rx_ready), 32'd0);
    @(negedge clk);
    cpu_ioreq = 1'b1;
    #1;
    chk("cpu_io_we", 32'(mem_we), 32'd0);
    chk("idle_stay", 32'(busy),   32'd0);
    rx_valid = 1'b0;

    // Gapped load, upper length nibble ignored, CPU and start ignored while loading
    do_start();
    xfer(8'hF0, 1'b0, 12'h000, "g_lh");
    @(negedge clk); rx_valid = 1'b0; #1;
    chk("g_gap0_we", 32'(mem_we), 32'd0);
    xfer(8'h02, 1'b0, 12'h000, "g_ll");
    @(negedge clk); rx_valid = 1'b0; #1;
    chk("g_gap1_we", 32'(mem_we), 32'd0);
    xfer(8'h11, 1'b1, 12'h000, "g_w0");
    @(negedge clk);
    rx_valid = 1'b0; start = 1'b1; cpu_we = 1'b1; cpu_ioreq = 1'b0;
    #1;
    chk("g_gap2_we",   32'(mem_we),   32'd0);
    chk("g_gap2_addr", 32'(mem_addr), 32'h001);
    chk("g_gap2_rdy",  32'(rx_ready), 32'd1);
    @(negedge clk); start = 1'b0; cpu_we = 1'b0;
    xfer(8'h22, 1'b1, 12'h001, "g_w1");
    release_chk("g");

    // Reset in the middle of DATA abandons the load
    do_start();
    xfer(8'h00, 1'b0, 12'h000, "r_lh");
    xfer(8'h05, 1'b0, 12'h000, "r_ll");
    xfer(8'h01, 1'b1, 12'h000, "r_w0");
    xfer(8'h02, 1'b1, 12'h001, "r_w1");
    @(negedge clk);
    rx_byte = 8'h03; rst = 1'b1;
    #1;
    chk("r_mid_we",     32'(mem_we),    32'd0);
    chk("r_mid_cpurst", 32'(cpu_reset), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    rx_byte = 8'h00;
    xfer(8'h01, 1'b0, 12'h000, "r2_ll");
    xfer(8'h7E, 1'b1, 12'h000, "r2_w0");
    release_chk("r2");

    // Full 4096-byte load (length 0)
    do_start();
    xfer(8'h00, 1'b0, 12'h000, "f_lh");
    xfer(8'h00, 1'b0, 12'h000, "f_ll");
    xfer(8'h00, 1'b1, 12'h000, "f_first");
    for (int i = 1; i < 4095; i++) xfer(8'(i), 1'b0, 12'h000, "f");
    #1;
    chk("f_pre_last_rdy", 32'(rx_ready), 32'd1);
    xfer(8'hEE, 1'b1, 12'hFFF, "f_last");
    release_chk("f");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish by 200000");
    $fatal(1, "timeout");
  end

endmodule
